// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the UART receive FIFO.
//   DEPTH_DEF  default number of FIFO entries
//   rx_entry_t one stored received frame {err, data}
package uart_pkg;

    localparam int DEPTH_DEF = 16;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } rx_entry_t;

    localparam int ENTRY_W = $bits(rx_entry_t);

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver-side and consumer-side signals of the UART RX FIFO.
//   rx_data/rx_ready/rx_error : byte, level-ready flag and stop-bit error from the receiver
//   rd_en/ovf_clr             : pop request and overflow clear from the consumer
//   rd_data/rd_err            : show-ahead head entry
//   empty/full/level/overflow : FIFO status
// slave modport is the FIFO side, master modport the driver side.
interface uart_rx_fifo_if #(parameter int DEPTH = 16);

    logic [7:0]              rx_data;
    logic                    rx_ready;
    logic                    rx_error;
    logic                    rd_en;
    logic                    ovf_clr;
    logic [7:0]              rd_data;
    logic                    rd_err;
    logic                    empty;
    logic                    full;
    logic [$clog2(DEPTH):0]  level;
    logic                    overflow;

    modport slave (
        input  rx_data, rx_ready, rx_error, rd_en, ovf_clr,
        output rd_data, rd_err, empty, full, level, overflow
    );

    modport master (
        output rx_data, rx_ready, rx_error, rd_en, ovf_clr,
        input  rd_data, rd_err, empty, full, level, overflow
    );

endinterface

// File: rtl/fifo_sync.sv
// fifo_sync: synchronous show-ahead FIFO, WIDTH bits x DEPTH entries (DEPTH power of two).
//   clk_i/rst_ni        : clock, async active-low reset (pointers only, memory not reset)
//   push_i/wdata_i      : write request and data; accepted when not full or when popping
//   pop_i               : read request; ignored while empty
//   rdata_o             : head entry, valid while empty_o=0
//   empty_o/full_o/level_o : status
module fifo_sync #(
    parameter  int WIDTH = 9,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [AW:0]      level_o
);

    // Counters carry one extra bit so that full and empty differ
    // (wcnt-rcnt = DEPTH vs 0); the low AW bits are the pointers.
    logic [AW:0]      wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic [AW-1:0]    wptr, rptr;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign wptr    = wcnt_q[AW-1:0];
    assign rptr    = rcnt_q[AW-1:0];
    assign level_o = wcnt_q - rcnt_q;
    assign empty_o = (level_o == '0);
    assign full_o  = (level_o == (AW+1)'(DEPTH));
    assign rdata_o = mem_q[rptr];

    // A pop frees a slot in the same cycle, so push is accepted at full
    // when a pop coincides.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wcnt_d = wcnt_q;
        rcnt_d = rcnt_q;
        if (do_push) wcnt_d = wcnt_q + 1'b1;
        if (do_pop)  rcnt_d = rcnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wcnt_q <= '0;
            rcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
            rcnt_q <= rcnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr] <= wdata_i;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: buffers bytes from a UART receiver for a consumer.
//   clk50m : system clock
//   rst_n  : async active-low reset
//   bus    : uart_rx_fifo_if.slave (receiver inputs, consumer pop/clear, FIFO status)
// One entry is pushed per rising edge of rx_ready. A push into a full FIFO
// without a simultaneous pop is dropped and sets the sticky overflow flag.
// Build option UART_RX_FIFO_ERR_DROP_EN: discard frames flagged with rx_error
// (they never count as overflow) and tie rd_err to 0.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk50m,
    input  logic          rst_n,
    uart_rx_fifo_if.slave bus
);

`ifdef UART_RX_FIFO_ERR_DROP_EN
    localparam bit ERR_DROP = 1'b1;
`else
    localparam bit ERR_DROP = 1'b0;
`endif

    localparam int AW = $clog2(DEPTH);

    logic      rdy_q, rdy_d;
    logic      armed_q, armed_d;
    logic      ovf_q, ovf_d;
    logic      push_req, push, pop_req;
    logic      fifo_empty, fifo_full;
    rx_entry_t wr_ent, rd_ent;

    // armed_q is cleared by reset and set once rx_ready is seen low, so a
    // receiver still holding rx_ready across reset does not re-push the
    // byte that reset just discarded.
    assign push_req = bus.rx_ready & ~rdy_q & armed_q;
    assign push     = push_req & ~(ERR_DROP & bus.rx_error);
    assign pop_req  = bus.rd_en & ~fifo_empty;

    assign wr_ent = '{err: bus.rx_error, data: bus.rx_data};

    always_comb begin
        rdy_d   = bus.rx_ready;
        armed_d = armed_q | ~bus.rx_ready;
        ovf_d   = ovf_q;
        // A new overflow takes priority over a coinciding clear.
        if (push && fifo_full && !pop_req) ovf_d = 1'b1;
        else if (bus.ovf_clr)              ovf_d = 1'b0;
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q   <= 1'b0;
            armed_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            rdy_q   <= rdy_d;
            armed_q <= armed_d;
            ovf_q   <= ovf_d;
        end
    end

    fifo_sync #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk50m),
        .rst_ni  (rst_n),
        .push_i  (push),
        .pop_i   (bus.rd_en),
        .wdata_i (wr_ent),
        .rdata_o (rd_ent),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (bus.level)
    );

    assign bus.rd_data  = rd_ent.data;
    assign bus.rd_err   = ERR_DROP ? 1'b0 : rd_ent.err;
    assign bus.empty    = fifo_empty;
    assign bus.full     = fifo_full;
    assign bus.overflow = ovf_q;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of FIFO entries; it is a power of two, minimum 2.
REQ-002 The block SHALL have one clock and one asynchronous, active-low reset.
REQ-003 Port clk50m  input  1  system clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port rx_data  input  8  received byte from the UART receiver.
REQ-006 Port rx_ready  input  1  level flag from the receiver: set at frame end, cleared at next start bit.
REQ-007 Port rx_error  input  1  stop-bit error flag, valid together with rx_ready.
REQ-008 Port rd_en  input  1  pop request from the consumer.
REQ-009 Port rd_data  output  8  head entry data (show-ahead).
REQ-010 Port rd_err  output  1  head entry error flag.
REQ-011 Port empty  output  1  FIFO holds zero entries.
REQ-012 Port full  output  1  FIFO holds DEPTH entries.
REQ-013 Port level  output  $clog2(DEPTH)+1  number of stored entries.
REQ-014 Port overflow  output  1  sticky flag: a byte was lost because the FIFO was full.
REQ-015 Port ovf_clr  input  1  synchronous clear of overflow.

Function
REQ-016 Capture: a push SHALL occur in the cycle where rx_ready=1 and its registered previous value is 0, so one push per frame regardless of how long rx_ready stays high.
REQ-017 A push SHALL store {rx_error, rx_data} sampled in the push cycle.
REQ-018 Latency: the pushed entry SHALL be visible on rd_data/rd_err, with empty=0, one cycle after the push cycle when the FIFO was empty.
REQ-019 A pop SHALL occur when rd_en=1 and empty=0; it advances the read pointer, and the next entry appears on the following cycle.
REQ-020 rd_en while empty SHALL be ignored: pointers unchanged, no error.
REQ-021 Push while full without a simultaneous pop SHALL drop the byte and set overflow on the next edge; stored contents are unchanged.
REQ-022 Simultaneous push and pop SHALL both succeed in every non-empty state, including full; level is unchanged.
REQ-023 Simultaneous push and pop while empty SHALL perform only the push.
REQ-024 Pointers SHALL be $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0; level SHALL be computed from write/push and read/pop counts with no modulo aliasing at full.
REQ-025 overflow SHALL stay set until ovf_clr=1; if ovf_clr and a new overflow coincide, overflow SHALL remain 1.
REQ-026 rd_data/rd_err SHALL be don't-care while empty; the bench checks them only when empty=0.

Reset
REQ-027 On rst_n=0, the block SHALL asynchronously clear pointers and level to 0, set empty=1, full=0, overflow=0, and clear the rx_ready history register to 0.
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 Reset mid-operation SHALL discard all entries; the first push after reset SHALL occur only on a fresh 0->1 transition of rx_ready.

Configuration
REQ-030 Macro UART_RX_FIFO_ERR_DROP_EN defined: a push with rx_error=1 SHALL be discarded and SHALL NOT affect overflow; rd_err SHALL be constant 0.
REQ-031 Macro UART_RX_FIFO_ERR_DROP_EN undefined: errored bytes SHALL be stored and flagged on rd_err.

Structure
REQ-032 Package uart_pkg SHALL hold the entry typedef (struct: err, data[7:0]) and the DEPTH default constant.
REQ-033 Storage and pointer logic SHALL be a sub-module named fifo_sync, parameterised by width and depth; uart_rx_fifo contains edge detection, error filtering, and the overflow flag.

Verification
REQ-034 Bench SHALL drive rx_data=8'hA5 with rx_ready held high for 50 cycles -> exactly one entry; rd_data=8'hA5, rd_err=0, level=1.
REQ-035 Bench SHALL push 16 bytes 8'h00..8'h0F with DEPTH=16, then push 8'hFF -> full=1, overflow=1; popping all entries yields 8'h00..8'h0F in order and then empty=1.
REQ-036 Bench SHALL, while full, push 8'h55 and assert rd_en in the same cycle -> level stays 16, overflow stays 0, and 8'h55 is the last entry popped.
REQ-037 Bench SHALL push 8'h3C with rx_error=1 -> with the macro undefined, rd_err=1 and rd_data=8'h3C; with the macro defined, empty stays 1.
REQ-038 Bench SHALL, with 5 entries stored, assert rst_n=0 mid-stream while rx_ready=1 -> level=0 and empty=1 immediately; after release there is no push until rx_ready goes 0 then 1.
REQ-039 Bench SHALL assert rd_en for 3 cycles while empty, then assert ovf_clr after an overflow -> pointers unchanged during the rd_en cycles; overflow=0 one cycle after ovf_clr.
